// File: rtl/router_pkg.sv
// Types and constants shared by the router control and datapath blocks.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_0       = 2'b00;
    localparam logic [1:0] ADDR_1       = 2'b01;
    localparam logic [1:0] ADDR_2       = 2'b10;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Picks the per-port flag for a destination address; the invalid address selects nothing.
    function automatic logic port_sel(input logic [2:0] flags, input logic [1:0] addr);
        case (addr)
            ADDR_0:  port_sel = flags[0];
            ADDR_1:  port_sel = flags[1];
            ADDR_2:  port_sel = flags[2];
            default: port_sel = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing control FSM for the 1x3 router: header decode, payload,
// full-stall recovery and parity load, driving router_register and the synchronizer.
module router_fsm
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       pkt_valid,
    input  logic [1:0] din,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_addr,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    state_t     state;
    state_t     next_state;
    logic [1:0] addr_q;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       hdr_valid;

    assign fifo_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_reset = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign hdr_valid  = (state == DECODE_ADDRESS) && pkt_valid && (din != ADDR_INVALID);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= DECODE_ADDRESS;
            addr_q <= ADDR_0;
        end else begin
            state <= next_state;
            if (hdr_valid)
                addr_q <= din;
        end
    end

    always_comb begin
        next_state = DECODE_ADDRESS;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && din != ADDR_INVALID)
                    next_state = port_sel(fifo_empty, din) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                else
                    next_state = DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY:
                next_state = port_sel(fifo_empty, addr_q) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:
                next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    next_state = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    next_state = LOAD_PARITY;
                else
                    next_state = LOAD_DATA;
            end
            FIFO_FULL_STATE:
                next_state = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    next_state = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    next_state = LOAD_PARITY;
                else
                    next_state = LOAD_DATA;
            end
            LOAD_PARITY:
                next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:
                next_state = DECODE_ADDRESS;
        endcase

        // A read timeout on the port being written abandons the packet from any state.
        if (port_sel(soft_reset, addr_q))
            next_state = DECODE_ADDRESS;
    end

    always_comb begin
        detect_addr   = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b1;
        case (state)
            DECODE_ADDRESS: begin
                detect_addr = 1'b1;
                busy        = 1'b0;
            end
            LOAD_FIRST_DATA:
                lfd_state = 1'b1;
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            FIFO_FULL_STATE:
                full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY:
                write_enb_reg = 1'b1;
            CHECK_PARITY_ERROR:
                rst_int_reg = 1'b1;
            WAIT_TILL_EMPTY: ;
            default: begin
                detect_addr = 1'b1;
                busy        = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control state machine for the 1x3 router. It sits directly upstream of router_register.
- Decodes the header address on din[1:0] and sequences header, payload, after-full and parity loading.
- Generates detect_addr, lfd_state, ld_state, laf_state, full_state and rst_int_reg for router_register, plus write_enb_reg and busy for the synchronizer and source.
- Consumes parity_done and low_pkt_valid back from router_register.

Parameters:
- None. Port count is fixed at 3; address 2'b11 is invalid.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- pkt_valid  in  1  source packet-valid strobe
- din  in  2  low two bits of source data bus (header address)
- fifo_full  in  1  full flag of the currently addressed FIFO (from synchronizer)
- fifo_empty_0  in  1  FIFO 0 empty
- fifo_empty_1  in  1  FIFO 1 empty
- fifo_empty_2  in  1  FIFO 2 empty
- soft_reset_0  in  1  FIFO 0 read-timeout soft reset
- soft_reset_1  in  1  FIFO 1 read-timeout soft reset
- soft_reset_2  in  1  FIFO 2 read-timeout soft reset
- parity_done  in  1  from router_register: parity byte captured
- low_pkt_valid  in  1  from router_register: pkt_valid fell while full
- detect_addr  out  1  state==DECODE_ADDRESS
- lfd_state  out  1  state==LOAD_FIRST_DATA
- ld_state  out  1  state==LOAD_DATA
- laf_state  out  1  state==LOAD_AFTER_FULL
- full_state  out  1  state==FIFO_FULL_STATE
- rst_int_reg  out  1  state==CHECK_PARITY_ERROR
- write_enb_reg  out  1  FIFO write enable
- busy  out  1  source must hold din

Behaviour:
- Moore machine. All outputs decode the registered state only.
- write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
- busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Reset (rstn low, asynchronous): state = DECODE_ADDRESS, addr_q = 2'b00. Outputs during and after reset: detect_addr=1, all others 0, busy=0.
- addr_q loads din[1:0] when state==DECODE_ADDRESS and pkt_valid=1 and din!=2'b11. It is held otherwise.
- Transitions, evaluated at the rising edge:
  - DECODE_ADDRESS:
    - pkt_valid and din=a (a in 0..2) and fifo_empty_a -> LOAD_FIRST_DATA
    - pkt_valid and din=a and !fifo_empty_a -> WAIT_TILL_EMPTY
    - din=3 or !pkt_valid -> stay
  - WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LOAD_FIRST_DATA; else stay.
  - LOAD_FIRST_DATA -> LOAD_DATA, unconditional.
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE
    - else !pkt_valid -> LOAD_PARITY
    - else stay
    - fifo_full has priority over !pkt_valid.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS
    - else low_pkt_valid -> LOAD_PARITY
    - else -> LOAD_DATA
  - LOAD_PARITY -> CHECK_PARITY_ERROR, unconditional.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
- Soft reset:
  - soft_reset[addr_q]=1 in any state forces next state = DECODE_ADDRESS. This overrides every other transition.
  - Soft resets of non-addressed ports are ignored.
- Latency:
  - Header accepted -> lfd_state=1 next cycle.
  - Payload bytes are written while ld_state=1.
  - The parity byte write happens in LOAD_PARITY, one cycle after pkt_valid falls.
  - rst_int_reg pulses one cycle later.
- Minimum packet (header, 1 payload byte, parity): DECODE → LFD → LD → LP → CPE → DECODE, with no stalls.
- Illegal or unused state encodings recover to DECODE_ADDRESS on the next edge.

Decomposition:
- Shared package router_pkg holds:
  - state enum typedef: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY
  - address constants ADDR_0/1/2 and ADDR_INVALID=2'b11
- The package is also used by router_register and router_sync.
- No sub-module. The design is a single state register, an address register and next-state/output decode.

Test Plan:
- Reset then idle: rstn=0 mid-LOAD_DATA -> immediately detect_addr=1, write_enb_reg=0, busy=0. With pkt_valid=0 after release, stays in DECODE_ADDRESS.
- Normal packet to port 1, fifo_empty_1=1, header 8'h0D, 3 payload bytes, parity:
  - lfd_state 1 cycle, ld_state 3 cycles, then LOAD_PARITY with write_enb_reg=1 and busy=1.
  - rst_int_reg pulses 1 cycle, then detect_addr=1.
- Busy destination: din=2'b10, fifo_empty_2=0 for 4 cycles -> WAIT_TILL_EMPTY, busy=1, write_enb_reg=0. fifo_empty_2 rises -> lfd_state next cycle.
- FIFO full mid-payload: fifo_full=1 in LOAD_DATA -> full_state=1, busy=1 until fifo_full=0, then laf_state=1 for 1 cycle. Three branches from there:
  - parity_done=0, low_pkt_valid=0 -> LOAD_DATA
  - low_pkt_valid=1 -> LOAD_PARITY
  - parity_done=1 -> DECODE_ADDRESS
- Soft reset: packet to port 0 stalled in FIFO_FULL_STATE, soft_reset_0=1 -> detect_addr=1 next cycle. soft_reset_2=1 in the same scenario has no effect.
- Invalid address: pkt_valid=1, din=2'b11 for 3 cycles -> remains DECODE_ADDRESS, busy=0, addr_q unchanged.
